bless_arb_ctrl: RTL and testbench



---
 rtl/bless_arb_ctrl_pkg.sv | 31 +++
 rtl/bless_arb_ctrl_if.sv | 24 ++
 rtl/bless_arb_ctrl_golden_epoch_cnt.sv | 41 ++++
 rtl/bless_arb_ctrl.sv | 106 ++++++++++
 tb/tb_bless_arb_ctrl.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/bless_arb_ctrl_pkg.sv
// Shared types and constants for the BLESS arbitration controller.
// Control word layout: {valid_f, gold_f, seq_f, src_f}.
package bless_arb_ctrl_pkg;

  localparam int unsigned NUM_PORTS = 4;
  localparam int unsigned PORT_W    = 2;
  localparam int unsigned SRC_W     = 4;
  localparam int unsigned SEQ_W     = 6;

  typedef logic [PORT_W-1:0] port_t;

  typedef struct packed {
    logic             valid_f;
    logic             gold_f;
    logic [SEQ_W-1:0] seq_f;
    logic [SRC_W-1:0] src_f;
  } ctrl_t;

  // prio0..prio3 = 0,1,2,3 packed with prio0 in the low bits
  localparam logic [NUM_PORTS*PORT_W-1:0] RESET_PRIO = 8'hE4;

  // Qualify with in_valid and tag gold; an incoming gold bit is never cleared
  function automatic ctrl_t gold_tag(ctrl_t w, logic in_valid, logic [SRC_W-1:0] gid);
    ctrl_t t;
    t         = w;
    t.valid_f = w.valid_f & in_valid;
    t.gold_f  = w.gold_f | (t.valid_f & (w.src_f == gid));
    return t;
  endfunction

endpackage

// File: rtl/bless_arb_ctrl_if.sv
// Bus between the arbitration controller, its upstream and the external comparator.
interface bless_arb_ctrl_if;
  import bless_arb_ctrl_pkg::*;

  logic                  in_valid;
  logic                  stall;
  ctrl_t [NUM_PORTS-1:0] ctrl;
  ctrl_t [NUM_PORTS-1:0] cmp_ctrl;
  port_t                 cmp_rr;
  port_t [NUM_PORTS-1:0] cmp_prio;
  port_t [NUM_PORTS-1:0] prio;
  logic                  prio_valid;

  modport master (
    output in_valid, stall, ctrl, cmp_prio,
    input  cmp_ctrl, cmp_rr, prio, prio_valid
  );

  modport slave (
    input  in_valid, stall, ctrl, cmp_prio,
    output cmp_ctrl, cmp_rr, prio, prio_valid
  );

endinterface

// File: rtl/bless_arb_ctrl_golden_epoch_cnt.sv
// Epoch cycle counter and golden source ID; the ID advances when the epoch wraps.
module bless_arb_ctrl_golden_epoch_cnt #(
  parameter int unsigned EPOCH_LEN = 256,
  parameter int unsigned NUM_NODES = 16,
  parameter int unsigned NODE_W    = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en,
  output logic [$clog2(EPOCH_LEN)-1:0] epoch_cnt_o,
  output logic [NODE_W-1:0]            golden_id_o
);

  localparam int unsigned EPOCH_W = $clog2(EPOCH_LEN);

  logic [EPOCH_W-1:0] epoch_q, epoch_d;
  logic [NODE_W-1:0]  gid_q, gid_d;

  always_comb begin
    epoch_d = epoch_q + EPOCH_W'(1);
    gid_d   = gid_q;
    if (epoch_q == EPOCH_W'(EPOCH_LEN - 1)) begin
      epoch_d = '0;
      gid_d   = (gid_q == NODE_W'(NUM_NODES - 1)) ? '0 : gid_q + NODE_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      epoch_q <= '0;
      gid_q   <= '0;
    end else if (en) begin
      epoch_q <= epoch_d;
      gid_q   <= gid_d;
    end
  end

  assign epoch_cnt_o = epoch_q;
  assign golden_id_o = gid_q;

endmodule

// File: rtl/bless_arb_ctrl.sv
// Two-stage sequencer around the external 4-port BLESS priority comparator.
// Optional starvation forcing of cmp_rr is enabled by defining ARB_STARVE_FORCE_EN.
module bless_arb_ctrl import bless_arb_ctrl_pkg::*; #(
  parameter int unsigned EPOCH_LEN  = 256,
  parameter int unsigned NUM_NODES  = 16,
  parameter int unsigned NODE_W     = 4
`ifdef ARB_STARVE_FORCE_EN
  , parameter int unsigned STARVE_MAX = 8
`endif
) (
  input  logic                         clk,
  input  logic                         rst_n,
  bless_arb_ctrl_if.slave              bus,
  output logic [NODE_W-1:0]            golden_id_o,
  output logic [$clog2(EPOCH_LEN)-1:0] epoch_cnt_o
);

  ctrl_t [NUM_PORTS-1:0] cmp_ctrl_d, cmp_ctrl_q;
  port_t [NUM_PORTS-1:0] prio_q;
  logic                  prio_valid_d, prio_valid_q;
  port_t                 rr_d, rr_q;

  bless_arb_ctrl_golden_epoch_cnt #(
    .EPOCH_LEN (EPOCH_LEN),
    .NUM_NODES (NUM_NODES),
    .NODE_W    (NODE_W)
  ) u_epoch (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (!bus.stall),
    .epoch_cnt_o (epoch_cnt_o),
    .golden_id_o (golden_id_o)
  );

  // Stage 1 capture with gold tagging against the pre-edge golden ID
  always_comb begin
    cmp_ctrl_d   = '0;
    prio_valid_d = 1'b0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      cmp_ctrl_d[p] = gold_tag(bus.ctrl[p], bus.in_valid, SRC_W'(golden_id_o));
      prio_valid_d  = prio_valid_d | cmp_ctrl_q[p].valid_f;
    end
  end

`ifdef ARB_STARVE_FORCE_EN
  localparam int unsigned STARVE_W = $clog2(STARVE_MAX + 1);

  logic [NUM_PORTS-1:0][STARVE_W-1:0] starve_d, starve_q;
  logic                               force_hit;
  port_t                              force_port;

  // Saturating per-port starvation counters; lowest starving port is forced
  always_comb begin
    force_hit  = 1'b0;
    force_port = '0;
    starve_d   = starve_q;
    for (int p = NUM_PORTS - 1; p >= 0; p--) begin
      if (starve_q[p] == STARVE_W'(STARVE_MAX)) begin
        force_hit  = 1'b1;
        force_port = PORT_W'(p);
      end
    end
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (prio_valid_q && prio_q[NUM_PORTS-1] == PORT_W'(p)
          && starve_q[p] != STARVE_W'(STARVE_MAX))
        starve_d[p] = starve_q[p] + STARVE_W'(1);
      if (prio_valid_q && prio_q[0] == PORT_W'(p))
        starve_d[p] = '0;
    end
    if (force_hit) starve_d[force_port] = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)          starve_q <= '0;
    else if (!bus.stall) starve_q <= starve_d;
  end
`endif

  always_comb begin
    rr_d = rr_q;
    if (prio_valid_d) rr_d = rr_q + PORT_W'(1);
`ifdef ARB_STARVE_FORCE_EN
    if (force_hit) rr_d = force_port;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cmp_ctrl_q   <= '0;
      prio_q       <= RESET_PRIO;
      prio_valid_q <= 1'b0;
      rr_q         <= '0;
    end else if (!bus.stall) begin
      cmp_ctrl_q   <= cmp_ctrl_d;
      prio_q       <= bus.cmp_prio;
      prio_valid_q <= prio_valid_d;
      rr_q         <= rr_d;
    end
  end

  assign bus.cmp_ctrl   = cmp_ctrl_q;
  assign bus.cmp_rr     = rr_q;
  assign bus.prio       = prio_q;
  assign bus.prio_valid = prio_valid_q;

endmodule

// File: tb/tb_bless_arb_ctrl.sv
// Directed self-checking bench for bless_arb_ctrl with a simple rotating comparator model.
module tb_bless_arb_ctrl;
  import bless_arb_ctrl_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [3:0] golden_id;
  logic [1:0] epoch_cnt;
  logic       ovr_en;

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;

  // golden_id / epoch_cnt / gold vector after edge k (k = 1..13), EPOCH_LEN=4, NUM_NODES=3
  int t2_gid  [13] = '{0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2, 0, 0};
  int t2_ep   [13] = '{1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3, 0, 1};
  int t2_gold [13] = '{4, 4, 4, 4, 6, 6, 6, 6, 4, 4, 4, 4, 4};

  bless_arb_ctrl_if bus ();

  bless_arb_ctrl #(
    .EPOCH_LEN (4),
    .NUM_NODES (3),
    .NODE_W    (4)
`ifdef ARB_STARVE_FORCE_EN
    , .STARVE_MAX (2)
`endif
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .golden_id_o (golden_id),
    .epoch_cnt_o (epoch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] prio_vec(input logic [1:0] b);
    logic [7:0] v;
    for (int k = 0; k < 4; k++) v[k*2 +: 2] = b + 2'(k);
    return v;
  endfunction

  // External comparator stand-in: order rotates from cmp_rr + port0 seq
  always_comb begin
    bus.cmp_prio = prio_vec(bus.cmp_rr + bus.cmp_ctrl[0].seq_f[1:0]);
    if (ovr_en) bus.cmp_prio = 8'hB4;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic ctrl_t mk(input logic v, input logic g, input logic [SEQ_W-1:0] seq,
                               input logic [SRC_W-1:0] src);
    ctrl_t w;
    w.valid_f = v;
    w.gold_f  = g;
    w.seq_f   = seq;
    w.src_f   = src;
    return w;
  endfunction

  task automatic drive(input logic iv, input logic [SEQ_W-1:0] seq);
    bus.in_valid = iv;
    bus.ctrl[0]  = mk(1'b1, 1'b0, seq, 4'd5);
    bus.ctrl[1]  = mk(1'b1, 1'b0, seq, 4'd6);
    bus.ctrl[2]  = mk(1'b1, 1'b0, seq, 4'd7);
    bus.ctrl[3]  = mk(1'b1, 1'b0, seq, 4'd8);
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    bus.stall    = 1'b0;
    bus.in_valid = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  function automatic logic [3:0] gold_bits();
    return {bus.cmp_ctrl[3].gold_f, bus.cmp_ctrl[2].gold_f,
            bus.cmp_ctrl[1].gold_f, bus.cmp_ctrl[0].gold_f};
  endfunction

  initial begin
    ovr_en   = 1'b0;
    bus.ctrl = '0;
    do_reset();
    check_eq("rst_pv",    32'(bus.prio_valid), 32'd0);
    check_eq("rst_prio",  32'(bus.prio),       32'hE4);
    check_eq("rst_rr",    32'(bus.cmp_rr),     32'd0);
    check_eq("rst_gid",   32'(golden_id),      32'd0);
    check_eq("rst_epoch", 32'(epoch_cnt),      32'd0);
    check_eq("rst_ctrl",  32'(bus.cmp_ctrl[0]) | 32'(bus.cmp_ctrl[3]), 32'd0);

    // Basic latency and round-robin stepping
    drive(1'b1, 6'd1); step();
    check_eq("t1_src0",  32'(bus.cmp_ctrl[0].src_f), 32'd5);
    check_eq("t1_src3",  32'(bus.cmp_ctrl[3].src_f), 32'd8);
    check_eq("t1_val",   32'(bus.cmp_ctrl[2].valid_f), 32'd1);
    check_eq("t1_pv_e1", 32'(bus.prio_valid), 32'd0);
    check_eq("t1_rr_e1", 32'(bus.cmp_rr), 32'd0);
    drive(1'b1, 6'd2); step();
    check_eq("t1_pv_e2",   32'(bus.prio_valid), 32'd1);
    check_eq("t1_rr_e2",   32'(bus.cmp_rr), 32'd1);
    check_eq("t1_prio_e2", 32'(bus.prio), 32'(prio_vec(2'd1)));
    drive(1'b1, 6'd3); step();
    check_eq("t1_rr_e3",   32'(bus.cmp_rr), 32'd2);
    check_eq("t1_prio_e3", 32'(bus.prio), 32'(prio_vec(2'd3)));
    check_eq("t1_gold",    32'(gold_bits()), 32'd0);
    check_eq("t1_epoch",   32'(epoch_cnt), 32'd3);

    // Golden epochs: port1 src=1 tagged only while golden_id==1
    do_reset();
    bus.in_valid = 1'b1;
    bus.ctrl[0]  = mk(1'b1, 1'b0, 6'd0, 4'd9);
    bus.ctrl[1]  = mk(1'b1, 1'b0, 6'd0, 4'd1);
    bus.ctrl[2]  = mk(1'b1, 1'b1, 6'd0, 4'd9);
    bus.ctrl[3]  = mk(1'b0, 1'b0, 6'd0, 4'd1);
    for (int k = 1; k <= 13; k++) begin
      step();
      check_eq($sformatf("t2_gid_%0d", k),   32'(golden_id),   t2_gid[k-1]);
      check_eq($sformatf("t2_epoch_%0d", k), 32'(epoch_cnt),   t2_ep[k-1]);
      check_eq($sformatf("t2_gold_%0d", k),  32'(gold_bits()), t2_gold[k-1]);
    end

    // Stall freezes everything; third set emerges three cycles late
    do_reset();
    drive(1'b1, 6'd1); step();
    drive(1'b1, 6'd2); step();
    check_eq("t3_prio_s1", 32'(bus.prio), 32'(prio_vec(2'd1)));
    drive(1'b1, 6'd0);
    bus.stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check_eq($sformatf("t3_hold_prio_%0d", k), 32'(bus.prio), 32'(prio_vec(2'd1)));
      check_eq($sformatf("t3_hold_pv_%0d", k),   32'(bus.prio_valid), 32'd1);
      check_eq($sformatf("t3_hold_rr_%0d", k),   32'(bus.cmp_rr), 32'd1);
      check_eq($sformatf("t3_hold_ep_%0d", k),   32'(epoch_cnt), 32'd2);
    end
    bus.stall = 1'b0;
    step();
    check_eq("t3_prio_s2", 32'(bus.prio), 32'(prio_vec(2'd3)));
    check_eq("t3_rr_s2",   32'(bus.cmp_rr), 32'd2);
    bus.in_valid = 1'b0;
    step();
    check_eq("t3_prio_s3", 32'(bus.prio), 32'(prio_vec(2'd2)));
    check_eq("t3_pv_s3",   32'(bus.prio_valid), 32'd1);
    check_eq("t3_rr_s3",   32'(bus.cmp_rr), 32'd3);
    step();
    check_eq("t3_pv_end",  32'(bus.prio_valid), 32'd0);
    check_eq("t3_rr_end",  32'(bus.cmp_rr), 32'd3);

    // in_valid gap of two cycles
    do_reset();
    drive(1'b1, 6'd1); step();
    check_eq("t4_pv_e1", 32'(bus.prio_valid), 32'd0);
    bus.in_valid = 1'b0; step();
    check_eq("t4_pv_e2", 32'(bus.prio_valid), 32'd1);
    check_eq("t4_rr_e2", 32'(bus.cmp_rr), 32'd1);
    step();
    check_eq("t4_pv_e3", 32'(bus.prio_valid), 32'd0);
    check_eq("t4_rr_e3", 32'(bus.cmp_rr), 32'd1);
    drive(1'b1, 6'd2); step();
    check_eq("t4_pv_e4", 32'(bus.prio_valid), 32'd0);
    check_eq("t4_rr_e4", 32'(bus.cmp_rr), 32'd1);
    bus.in_valid = 1'b0; step();
    check_eq("t4_pv_e5",   32'(bus.prio_valid), 32'd1);
    check_eq("t4_rr_e5",   32'(bus.cmp_rr), 32'd2);
    check_eq("t4_prio_e5", 32'(bus.prio), 32'(prio_vec(2'd3)));
    step();
    check_eq("t4_pv_e6", 32'(bus.prio_valid), 32'd0);
    check_eq("t4_rr_e6", 32'(bus.cmp_rr), 32'd2);

    // Reset with two sets in flight, asserted together with stall
    do_reset();
    drive(1'b1, 6'd1); step();
    drive(1'b1, 6'd2); step();
    check_eq("t5_pv_pre", 32'(bus.prio_valid), 32'd1);
    rst_n     = 1'b0;
    bus.stall = 1'b1;
    step();
    check_eq("t5_pv",    32'(bus.prio_valid), 32'd0);
    check_eq("t5_prio",  32'(bus.prio), 32'hE4);
    check_eq("t5_rr",    32'(bus.cmp_rr), 32'd0);
    check_eq("t5_epoch", 32'(epoch_cnt), 32'd0);
    check_eq("t5_ctrl",  32'(bus.cmp_ctrl[0].valid_f), 32'd0);
    rst_n        = 1'b1;
    bus.stall    = 1'b0;
    bus.in_valid = 1'b0;
    step();
    check_eq("t5_pv_post", 32'(bus.prio_valid), 32'd0);
    check_eq("t5_rr_post", 32'(bus.cmp_rr), 32'd0);

`ifdef ARB_STARVE_FORCE_EN
    // Port 2 held last twice -> cmp_rr forced to 2, then counter restarts
    do_reset();
    ovr_en = 1'b1;
    drive(1'b1, 6'd0);
    for (int k = 1; k <= 4; k++) begin
      step();
      check_eq($sformatf("t6_rr_%0d", k), 32'(bus.cmp_rr), 32'(k - 1));
    end
    step();
    check_eq("t6_rr_force", 32'(bus.cmp_rr), 32'd2);
    step();
    check_eq("t6_rr_after", 32'(bus.cmp_rr), 32'd3);
    ovr_en = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
